// File: rtl/block_sync_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// block_sync_ctrl_pkg
// Shared definitions for the 64b/67b block synchroniser:
//   - sync_state_e      : FSM state encoding (also driven on the debug port)
//   - SH_DATA / SH_CTRL : the two legal 2-bit sync header values
//   - DEF_*             : default lock/monitor window parameters
//   - is_valid_header() : legal-header test used by the FSM
// ----------------------------------------------------------------------------
package block_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_WAIT = 2'd2,
    ST_LOCKED    = 2'd3
  } sync_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int DEF_SH_CNT_MAX         = 64;
  localparam int DEF_SH_INVALID_CNT_MAX = 16;
  localparam int DEF_SLIP_WAIT_CYCLES   = 32;

  function automatic logic is_valid_header(input logic [1:0] hdr);
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_ctrl.sv
// ----------------------------------------------------------------------------
// block_sync_ctrl
// Word-boundary (block) lock for a 64b/67b receive lane. Hunts for a run of
// SH_CNT_MAX legal sync headers, slips the gearbox one bit on any illegal
// header while hunting, and once locked drops lock when SH_INVALID_CNT_MAX
// illegal headers fall inside one SH_CNT_MAX-header window.
//
// Ports
//   USER_CLK          in   clock, all logic on the rising edge
//   SYSTEM_RESET      in   synchronous active-high reset
//   ENABLE            in   lane enable, low holds the block in HUNT
//   HEADER_IN[1:0]    in   sync header of the current word
//   HEADER_VALID      in   HEADER_IN qualifier
//   BITSLIP           out  one-cycle slip request to the gearbox (registered)
//   BLOCK_LOCK        out  word boundary locked (registered)
//   DESCR_DATA_VALID  out  HEADER_VALID & BLOCK_LOCK, combinational
//   SLIP_COUNT[7:0]   out  saturating number of slips since reset
//   state_dbg         out  current FSM state, for debug/checkers
//
// Header interface: the gearbox presents a header by raising HEADER_VALID for
// one cycle; there is no backpressure, so every qualified header is consumed
// on the rising edge at which it is sampled (or deliberately ignored while a
// slip is settling).
// ----------------------------------------------------------------------------
module block_sync_ctrl
  import block_sync_ctrl_pkg::*;
#(
  parameter int SH_CNT_MAX         = DEF_SH_CNT_MAX,
  parameter int SH_INVALID_CNT_MAX = DEF_SH_INVALID_CNT_MAX,
  parameter int SLIP_WAIT_CYCLES   = DEF_SLIP_WAIT_CYCLES
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic        ENABLE,
  input  logic [1:0]  HEADER_IN,
  input  logic        HEADER_VALID,
  output logic        BITSLIP,
  output logic        BLOCK_LOCK,
  output logic        DESCR_DATA_VALID,
  output logic [7:0]  SLIP_COUNT,
  output sync_state_e state_dbg
);

  localparam int SH_W   = $clog2(SH_CNT_MAX) + 1;
  localparam int INV_W  = $clog2(SH_INVALID_CNT_MAX) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES) + 1;

  sync_state_e       state_q, state_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bitslip_q, bitslip_d;
  logic              block_lock_q, block_lock_d;
  logic [7:0]        slip_count_q, slip_count_d;

  logic              hdr_ok;
  logic [SH_W-1:0]   sh_inc;
  logic [INV_W-1:0]  inv_inc;
  logic [7:0]        slip_sat;

  always_comb begin
    hdr_ok   = is_valid_header(HEADER_IN);
    sh_inc   = sh_cnt_q + SH_W'(1);
    inv_inc  = inv_cnt_q + INV_W'(1);
    slip_sat = (slip_count_q == 8'hFF) ? slip_count_q : slip_count_q + 8'd1;

    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    inv_cnt_d    = inv_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    bitslip_d    = 1'b0;
    block_lock_d = block_lock_q;
    slip_count_d = slip_count_q;

    if (!ENABLE) begin
      state_d      = ST_HUNT;
      sh_cnt_d     = '0;
      inv_cnt_d    = '0;
      wait_cnt_d   = '0;
      block_lock_d = 1'b0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          block_lock_d = 1'b0;
          if (HEADER_VALID) begin
            if (hdr_ok) begin
              if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                state_d      = ST_LOCKED;
                sh_cnt_d     = '0;
                inv_cnt_d    = '0;
                block_lock_d = 1'b1;
              end else begin
                sh_cnt_d = sh_inc;
              end
            end else begin
              // The slip pulse and its count are registered on entry to SLIP,
              // so a slip is counted as soon as it is visible to the gearbox.
              state_d      = ST_SLIP;
              sh_cnt_d     = '0;
              inv_cnt_d    = '0;
              bitslip_d    = 1'b1;
              slip_count_d = slip_sat;
            end
          end
        end

        ST_SLIP: begin
          state_d    = ST_SLIP_WAIT;
          wait_cnt_d = WAIT_W'(SLIP_WAIT_CYCLES);
        end

        ST_SLIP_WAIT: begin
          // Headers are ignored while the gearbox settles.
          if (wait_cnt_q <= WAIT_W'(1)) begin
            state_d    = ST_HUNT;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q - WAIT_W'(1);
          end
        end

        ST_LOCKED: begin
          if (HEADER_VALID) begin
            // Loss of lock is tested first so it wins over the window end.
            if (!hdr_ok && (inv_inc == INV_W'(SH_INVALID_CNT_MAX))) begin
              state_d      = ST_SLIP;
              sh_cnt_d     = '0;
              inv_cnt_d    = '0;
              bitslip_d    = 1'b1;
              block_lock_d = 1'b0;
              slip_count_d = slip_sat;
            end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
              sh_cnt_d  = '0;
              inv_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_inc;
              if (!hdr_ok) inv_cnt_d = inv_inc;
            end
          end
        end

        default: begin
          state_d      = ST_HUNT;
          sh_cnt_d     = '0;
          inv_cnt_d    = '0;
          wait_cnt_d   = '0;
          block_lock_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state_q      <= ST_HUNT;
      sh_cnt_q     <= '0;
      inv_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      block_lock_q <= 1'b0;
      slip_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      inv_cnt_q    <= inv_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      bitslip_q    <= bitslip_d;
      block_lock_q <= block_lock_d;
      slip_count_q <= slip_count_d;
    end
  end

  assign BITSLIP          = bitslip_q;
  assign BLOCK_LOCK       = block_lock_q;
  assign SLIP_COUNT       = slip_count_q;
  assign DESCR_DATA_VALID = HEADER_VALID & block_lock_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/block_sync_ctrl.md
BLOCK_SYNC_CTRL -- requirements
Module: block_sync_ctrl

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64: sync headers per lock/monitor window.
REQ-002 SHALL have parameter SH_INVALID_CNT_MAX, default 16: invalid headers per window that force loss of lock.
REQ-003 SHALL have parameter SLIP_WAIT_CYCLES, default 32: USER_CLK cycles allowed for the gearbox to settle after a bitslip.
REQ-004 SHALL have port USER_CLK, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port SYSTEM_RESET, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ENABLE, input, 1: lane enable; low holds the block idle.
REQ-007 SHALL have port HEADER_IN, input, 2: sync header of the current 67-bit word from the gearbox.
REQ-008 SHALL have port HEADER_VALID, input, 1: HEADER_IN qualifies this cycle.
REQ-009 SHALL have port BITSLIP, output, 1: one-cycle slip request to the gearbox.
REQ-010 SHALL have port BLOCK_LOCK, output, 1: word boundary locked.
REQ-011 SHALL have port DESCR_DATA_VALID, output, 1: DATA_VALID drive for the descrambler.
REQ-012 SHALL have port SLIP_COUNT, output, 8: saturating count of bitslips issued since reset.

Function
REQ-013 SHALL treat a header as valid when HEADER_IN is 2'b01 or 2'b10, and as invalid when it is 2'b00 or 2'b11; SHALL evaluate headers only in cycles where HEADER_VALID=1.
REQ-014 SHALL implement states HUNT, SLIP, SLIP_WAIT and LOCKED, with all outputs registered except DESCR_DATA_VALID.
REQ-015 In HUNT: a valid header SHALL increment sh_cnt; the valid header that brings sh_cnt to SH_CNT_MAX SHALL cause a transition to LOCKED, with BLOCK_LOCK=1 from the next cycle and both counters cleared.
REQ-016 In HUNT: an invalid header SHALL clear sh_cnt and cause a transition to SLIP.
REQ-017 In SLIP: BITSLIP SHALL be 1 for exactly one cycle, SLIP_COUNT SHALL increment (saturating at 255), the wait counter SHALL load, and the state SHALL go to SLIP_WAIT.
REQ-018 In SLIP_WAIT: the block SHALL count SLIP_WAIT_CYCLES cycles regardless of HEADER_VALID, ignore headers, then return to HUNT with counters cleared.
REQ-019 In LOCKED: every header SHALL increment sh_cnt, and invalid headers SHALL also increment inv_cnt.
REQ-020 In LOCKED: the invalid header that brings inv_cnt to SH_INVALID_CNT_MAX SHALL cause a transition to SLIP, with BLOCK_LOCK=0 from the next cycle.
REQ-021 In LOCKED: when sh_cnt reaches SH_CNT_MAX without loss of lock, both counters SHALL clear and the state SHALL remain LOCKED.
REQ-022 If the window end and the SH_INVALID_CNT_MAX-th invalid header coincide, loss of lock SHALL take priority.
REQ-023 DESCR_DATA_VALID SHALL equal HEADER_VALID AND BLOCK_LOCK (combinational, zero latency), so the descrambler resets its own state whenever block lock drops.
REQ-024 When ENABLE=0, the state SHALL go to HUNT on the next edge, counters SHALL clear, BITSLIP=0 and BLOCK_LOCK=0; SLIP_COUNT SHALL be held.
REQ-025 ENABLE deassertion in SLIP or SLIP_WAIT SHALL abort the slip sequence; a slip already issued SHALL remain counted.
REQ-026 Counter widths SHALL be $clog2 of their maximum plus 1, and no counter SHALL wrap.

Reset
REQ-027 On SYSTEM_RESET=1 at a rising edge, the state SHALL go to HUNT; sh_cnt, inv_cnt and the wait counter SHALL clear; BITSLIP=0, BLOCK_LOCK=0, SLIP_COUNT=0.
REQ-028 SYSTEM_RESET SHALL have priority over ENABLE and over all state transitions, including a reset asserted mid-slip or while locked.

Structure
REQ-029 A shared package SHALL hold the state encoding, the valid header constants 2'b01/2'b10, and the default window parameters.
REQ-030 The block SHALL be a single module with no sub-module; it instantiates beside the descrambler, and its DESCR_DATA_VALID drives the descrambler's DATA_VALID.

Verification
REQ-031 The bench SHALL cover: 64 valid headers after reset -> BLOCK_LOCK=1 one cycle after the 64th, BITSLIP never asserted.
REQ-032 The bench SHALL cover: invalid header 00 as the 10th header in HUNT -> one-cycle BITSLIP, SLIP_COUNT=1, no header evaluation for 32 cycles, then HUNT restarts at sh_cnt=0.
REQ-033 The bench SHALL cover: locked, 15 invalid headers in one window -> lock held and counters cleared at the window end; 16 invalid in the next window -> BLOCK_LOCK=0 and BITSLIP pulse.
REQ-034 The bench SHALL cover: locked, 16th invalid header as the 64th header of the window -> loss of lock (priority rule).
REQ-035 The bench SHALL cover: 300 forced slips -> SLIP_COUNT saturates at 255.
REQ-036 The bench SHALL cover: SYSTEM_RESET or ENABLE=0 asserted during SLIP_WAIT -> HUNT next cycle, BLOCK_LOCK=0, DESCR_DATA_VALID=0; SLIP_COUNT cleared only by reset.
